// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_scoreboard
// Description : Tracks in-flight register writes, forwards the youngest result
//               to decode and raises load-use stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_scoreboard #(
   parameter int DATA_W     = 32,
   parameter int AW         = 5,
   parameter int NSTAGE     = 3,
   parameter int LOAD_READY = 3,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(NSTAGE + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [AW-1:0]            id_rs,
   input  logic [AW-1:0]            id_rt,
   input  logic                     id_rs_used,
   input  logic                     id_rt_used,
   input  logic                     id_wr_en,
   input  logic [AW-1:0]            id_wr_addr,
   input  logic                     id_is_load,
   input  logic [DATA_W-1:0]        rf_rs_val,
   input  logic [DATA_W-1:0]        rf_rt_val,
   input  logic [NSTAGE*DATA_W-1:0] stage_val,
   input  logic                     hold,
   input  logic                     flush,
   output logic [DATA_W-1:0]        rs_val,
   output logic [DATA_W-1:0]        rt_val,
   output logic [SEL_W-1:0]         rs_sel,
   output logic [SEL_W-1:0]         rt_sel,
   output logic                     stall_d,
   output logic                     freeze_d,
   output logic [CNT_W-1:0]         stall_cnt
);

   logic [NSTAGE:1] sb_valid;
   logic [NSTAGE:1] sb_wr_en;
   logic [NSTAGE:1] sb_is_load;
   logic [AW-1:0]   sb_addr [1:NSTAGE];

   logic [AW-1:0]     src_addr [2];
   logic              src_used [2];
   logic [DATA_W-1:0] src_rf   [2];

   assign src_addr[0] = id_rs;
   assign src_addr[1] = id_rt;
   assign src_used[0] = id_rs_used;
   assign src_used[1] = id_rt_used;
   assign src_rf[0]   = rf_rs_val;
   assign src_rf[1]   = rf_rt_val;

   // Scanning from oldest to youngest lets the youngest writer overwrite last.
   for (genvar s = 0; s < 2; s++) begin : g_src
      logic [SEL_W-1:0]  sel;
      logic              rdy;
      logic [DATA_W-1:0] val;

      always_comb begin
         sel = '0;
         rdy = 1'b1;
         val = src_rf[s];
         for (int k = NSTAGE; k >= 1; k--) begin
            if (src_used[s] && (src_addr[s] != '0) && sb_valid[k] &&
                sb_wr_en[k] && (sb_addr[k] == src_addr[s])) begin
               sel = SEL_W'(k);
               rdy = !sb_is_load[k] || (k >= LOAD_READY);
               val = stage_val[(k-1)*DATA_W +: DATA_W];
            end
         end
         if (!rdy) begin
            val = src_rf[s];
         end
      end
   end

   assign rs_sel   = g_src[0].sel;
   assign rt_sel   = g_src[1].sel;
   assign rs_val   = g_src[0].val;
   assign rt_val   = g_src[1].val;
   assign stall_d  = id_valid && (!g_src[0].rdy || !g_src[1].rdy);
   assign freeze_d = stall_d || hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         sb_valid   <= '0;
         sb_wr_en   <= '0;
         sb_is_load <= '0;
         for (int k = 1; k <= NSTAGE; k++) begin
            sb_addr[k] <= '0;
         end
         stall_cnt  <= '0;
      end else if (hold) begin
         // A flush during a bus wait still kills the entry in stage 1.
         if (flush) begin
            sb_valid[1] <= 1'b0;
         end
      end else begin
         for (int k = NSTAGE; k >= 2; k--) begin
            sb_valid[k]   <= sb_valid[k-1];
            sb_wr_en[k]   <= sb_wr_en[k-1];
            sb_is_load[k] <= sb_is_load[k-1];
            sb_addr[k]    <= sb_addr[k-1];
         end
         sb_valid[1]   <= id_valid && !stall_d && !flush;
         sb_wr_en[1]   <= id_wr_en;
         sb_is_load[1] <= id_is_load;
         sb_addr[1]    <= id_wr_addr;
         if (stall_d && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_scoreboard
// Description : Randomized bench for pipe_hazard_scoreboard against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_scoreboard;

   localparam int NS = 3;
   localparam int DW = 32;
   localparam int LR = 3;

   logic           clk = 1'b0;
   logic           reset, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
   logic [4:0]     id_rs, id_rt, id_wr_addr;
   logic [DW-1:0]  rf_rs_val, rf_rt_val;
   logic [NS*DW-1:0] stage_val;
   logic           hold, flush;

   logic [DW-1:0]  rs_val, rt_val, s_rs_val, s_rt_val;
   logic [1:0]     rs_sel, rt_sel, s_rs_sel, s_rt_sel;
   logic           stall_d, freeze_d, s_stall_d, s_freeze_d;
   logic [15:0]    stall_cnt;
   logic [1:0]     s_stall_cnt;

   pipe_hazard_scoreboard u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .rf_rs_val(rf_rs_val),
      .rf_rt_val(rf_rt_val), .stage_val(stage_val), .hold(hold), .flush(flush),
      .rs_val(rs_val), .rt_val(rt_val), .rs_sel(rs_sel), .rt_sel(rt_sel),
      .stall_d(stall_d), .freeze_d(freeze_d), .stall_cnt(stall_cnt));

   pipe_hazard_scoreboard #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
      .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .rf_rs_val(rf_rs_val),
      .rf_rt_val(rf_rt_val), .stage_val(stage_val), .hold(hold), .flush(flush),
      .rs_val(s_rs_val), .rt_val(s_rt_val), .rs_sel(s_rs_sel), .rt_sel(s_rt_sel),
      .stall_d(s_stall_d), .freeze_d(s_freeze_d), .stall_cnt(s_stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit       we;
      bit       ld;
      bit [4:0] a;
   } ent_t;

   ent_t pipe[$];     // index 0 is the youngest (stage 1)
   int   model_cnt;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic lookup(input bit used, input bit [4:0] a, input bit [DW-1:0] rf,
                         output int sel, output bit rdy, output bit [DW-1:0] val);
      sel = 0;
      rdy = 1'b1;
      val = rf;
      if (used && a != 5'd0) begin
         for (int i = 0; i < NS; i++) begin
            if (pipe[i].v && pipe[i].we && pipe[i].a == a) begin
               sel = i + 1;
               rdy = !pipe[i].ld || (i + 1 >= LR);
               if (rdy) val = stage_val[i*DW +: DW];
               break;
            end
         end
      end
   endtask

   task automatic model_reset();
      pipe.delete();
      for (int i = 0; i < NS; i++) pipe.push_back('{v: 1'b0, we: 1'b0, ld: 1'b0, a: 5'd0});
      model_cnt = 0;
   endtask

   // Inputs are already applied; compare mid-cycle, then advance the model at the edge.
   task automatic cycle();
      int sel_s, sel_t;
      bit rdy_s, rdy_t, e_stall;
      bit [DW-1:0] val_s, val_t;
      ent_t n;
      #4;
      lookup(id_rs_used, id_rs, rf_rs_val, sel_s, rdy_s, val_s);
      lookup(id_rt_used, id_rt, rf_rt_val, sel_t, rdy_t, val_t);
      e_stall = id_valid && (!rdy_s || !rdy_t);
      check("rs_sel", rs_sel, sel_s);
      check("rt_sel", rt_sel, sel_t);
      if (rdy_s) check("rs_val", rs_val, val_s);
      if (rdy_t) check("rt_val", rt_val, val_t);
      check("stall_d", stall_d, e_stall);
      check("freeze_d", freeze_d, e_stall || hold);
      check("stall_cnt", stall_cnt, (model_cnt > 65535) ? 65535 : model_cnt);
      check("stall_cnt_sat", s_stall_cnt, (model_cnt > 3) ? 3 : model_cnt);
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (hold) begin
         if (flush) pipe[0].v = 1'b0;
      end else begin
         if (e_stall) model_cnt++;
         n.v  = id_valid && !e_stall && !flush;
         n.we = id_wr_en;
         n.ld = id_is_load;
         n.a  = id_wr_addr;
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
      #1;
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                         input bit rtu, input bit we, input bit [4:0] wa, input bit ld);
      id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b0; flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      rf_rs_val = 32'h1234; rf_rt_val = 32'h5678;
      stage_val = {32'h33, 32'h22, 32'h11};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cycle();                               // reset state visible
      reset = 1'b0;

      // Forward from E, then a load-use stall resolved from W.
      set_id(1, 0, 0, 0, 0, 1, 5'd3, 0); cycle();
      set_id(1, 5'd3, 1, 0, 0, 1, 5'd4, 1); cycle();
      set_id(1, 0, 0, 5'd4, 1, 0, 0, 0);
      repeat (3) cycle();
      // Register zero never forwards.
      set_id(1, 0, 0, 0, 0, 1, 5'd0, 0); cycle();
      set_id(1, 5'd0, 1, 0, 0, 0, 0, 0); cycle();
      // Load in M held under bus wait.
      set_id(1, 0, 0, 0, 0, 1, 5'd6, 1); cycle();
      set_id(1, 5'd6, 1, 0, 0, 0, 0, 0); cycle();
      hold = 1'b1; repeat (3) cycle();
      hold = 1'b0; repeat (2) cycle();

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         hold      = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 9) == 0);
         set_id($urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
         rf_rs_val = $urandom;
         rf_rt_val = $urandom;
         stage_val = {$urandom, $urandom, $urandom};
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised successor to the core's hard-wired hazard/forwarding logic. Tracks every in-flight register write for a configurable number of post-decode stages.
- Forwards the youngest matching result to the decode stage.
- Inserts decode bubbles when a load result is not yet available.
- Freezes cleanly while the data bus is waiting.
- Sits between decode and the regfile/pipeline registers of the core, replacing the fixed E/M/W comparator network.

Parameters:
- DATA_W, 32, width of register values
- AW, 5, register address width (register 0 hard-wired zero)
- NSTAGE, 3, number of tracked stages after decode (1 = E, 2 = M, 3 = W)
- LOAD_READY, 3, first stage index whose value is valid for a load
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  AW  source register A
- id_rt  in  AW  source register B
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register
- id_wr_addr  in  AW  destination register
- id_is_load  in  1  instruction is a load
- rf_rs_val  in  DATA_W  regfile read value for rs
- rf_rt_val  in  DATA_W  regfile read value for rt
- stage_val  in  NSTAGE*DATA_W  result value of stage k at bits (k-1)*DATA_W +: DATA_W
- hold  in  1  bus wait; freeze entire pipeline
- flush  in  1  kill the instruction entering stage 1
- rs_val  out  DATA_W  forwarded rs value
- rt_val  out  DATA_W  forwarded rt value
- rs_sel  out  $clog2(NSTAGE+1)  0 = regfile, k = stage k
- rt_sel  out  $clog2(NSTAGE+1)  same encoding for rt
- stall_d  out  1  data hazard: hold fetch/decode, bubble into stage 1
- freeze_d  out  1  stall_d | hold
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- State: entries sb[1..NSTAGE], each {valid, wr_en, addr, is_load}, plus stall_cnt.
- Reset (synchronous, high): all sb valid = 0 and stall_cnt = 0 on the next edge.
- After reset, the scoreboard is empty, so rs_val/rt_val = rf values, sels = 0, stall_d = 0.
- Advance when hold=0:
  - sb[k] <= sb[k-1] for k = 2..NSTAGE.
  - The entry in sb[NSTAGE] retires.
  - sb[1] <= decode entry if id_valid & !stall_d & !flush, else a bubble (valid = 0).
- hold=1:
  - All sb entries hold their value.
  - stall_cnt holds.
  - Exception: flush=1 still clears sb[1].valid.
- Match for source s (rs or rt): requires s_used, addr != 0, and some k with sb[k].valid & sb[k].wr_en & sb[k].addr == s.
  - The smallest such k (youngest writer) wins.
- Readiness: a matching entry is ready if !sb[k].is_load or k >= LOAD_READY.
- Outputs for each source:
  - No match: val = rf value, sel = 0.
  - Match and ready: val = stage_val slice k, sel = k.
  - Match and not ready: sel = k, val = rf value (don't care), contributes to stall_d.
- Unused sources and register 0 never match and never stall.
- stall_d = id_valid & (rs not ready | rt not ready). It is purely combinational from the current sb and id inputs; there is no added latency.
- stall_cnt increments by 1 on each edge where stall_d=1 & hold=0 & !reset, and saturates at all-ones.
- Simultaneous events:
  - reset overrides all.
  - flush overrides the id entry.
  - hold freezes everything except the flush clear.
- A self-dependent instruction (wr_addr == rs) matches only older entries, never itself.

Test Plan:
- Defaults. Write $3 enters E (stage_val E = 0x11), next decode reads rs=$3 -> rs_sel=1, rs_val=0x11, stall_d=0.
- Load to $4 enters E, next decode reads rt=$4 -> stall_d=1 for 2 cycles, then rt_sel=3 with the W value, stall_cnt=2.
- Decode reads $0 while E writes $0 with 0xDEAD -> rs_sel=0, rs_val=rf value, stall_d=0.
- Writes to $5 in E (0xA) and M (0xB), decode reads $5 -> rs_sel=1, rs_val=0xA.
- Load to $6 in M, then hold=1 for 3 cycles -> sb unchanged, stall_d stays 1, stall_cnt unchanged. hold drops -> load reaches W, next cycle forward with sel=3.
- reset asserted mid-stall with sb full -> next cycle all sels 0, stall_d=0, stall_cnt=0. Separately, CNT_W=2 with 5 stall cycles -> stall_cnt saturates at 3.
